// File: rtl/seg_scan_if.sv
// Bus between the value-producing logic, the shared 7-segment decoder and the
// seg_scan_controller. The master side writes digits and commits; the slave side scans.
interface seg_scan_if #(
    parameter int DIGITS = 4
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [3:0]        wr_data;
    logic              commit_req;
    logic              commit_ack;
    logic              blank_lz;
    logic [3:0]        dec_number;
    logic [6:0]        dec_digital;
    logic [6:0]        seg;
    logic [DIGITS-1:0] digit_en;
    logic              frame_start;

    modport master (
        output wr_en, wr_idx, wr_data, commit_req, blank_lz, dec_digital,
        input  commit_ack, dec_number, seg, digit_en, frame_start
    );

    modport slave (
        input  wr_en, wr_idx, wr_data, commit_req, blank_lz, dec_digital,
        output commit_ack, dec_number, seg, digit_en, frame_start
    );
endinterface

// File: rtl/seg_scan_controller.sv
// Time-multiplexed 7-segment scan controller: double-buffered BCD digit store,
// SCAN/GUARD digit stepping, leading-zero blanking and registered segment/digit outputs.
module seg_scan_controller #(
    parameter int DIGITS       = 4,
    parameter int SCAN_CYCLES  = 1000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);
    localparam int IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int MAX_CNT   = (SCAN_CYCLES > GUARD_CYCLES) ? SCAN_CYCLES : GUARD_CYCLES;
    localparam int CNT_W     = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam bit HAS_GUARD = (GUARD_CYCLES > 0);

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    localparam logic [0:0] ST_SCAN  = 1'b0;
    localparam logic [0:0] ST_GUARD = 1'b1;

    // Digit i>0 is a leading zero when it and every more significant digit are zero.
    function automatic logic [DIGITS-1:0] lz_mask(input logic [DIGITS-1:0] nz);
        logic seen;
        lz_mask = '0;
        seen    = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            seen       = seen | nz[i];
            lz_mask[i] = ~seen;
        end
    endfunction

    logic [3:0]        shadow_r [DIGITS];
    logic [3:0]        active_r [DIGITS];
    logic [0:0]        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  idx_r;
    logic [6:0]        seg_r;
    logic [DIGITS-1:0] digit_en_r;
    logic              commit_ack_r;
    logic              frame_start_r;

    logic [0:0]        state_nxt_s;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [IDX_W-1:0]  idx_nxt_s;
    logic              step_s;
    logic              wrap_s;
    logic              commit_s;
    logic [DIGITS-1:0] nz_s;
    logic [DIGITS-1:0] lz_mask_s;
    logic              blanked_s;
    logic [DIGITS-1:0] digit_sel_s;

    // Scan sequencing: dwell in SCAN, optional GUARD, then advance to the next digit.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + CNT_W'(1);
        idx_nxt_s   = idx_r;
        step_s      = 1'b0;
        case (state_r)
            ST_SCAN: begin
                if (cnt_r == SCAN_LAST) begin
                    cnt_nxt_s = '0;
                    if (HAS_GUARD) begin
                        state_nxt_s = ST_GUARD;
                    end else begin
                        step_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_GUARD: begin
                if (cnt_r == GUARD_LAST) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_SCAN;
                    step_s      = 1'b1;
                end else begin
                    state_nxt_s = ST_GUARD;
                end
            end
            default: begin
                state_nxt_s = ST_SCAN;
                cnt_nxt_s   = '0;
            end
        endcase
        if (step_s) begin
            idx_nxt_s = (idx_r == IDX_LAST) ? '0 : (idx_r + IDX_W'(1));
        end else begin
            idx_nxt_s = idx_r;
        end
        wrap_s   = step_s & (idx_r == IDX_LAST);
        commit_s = wrap_s & bus.commit_req;
    end

    // Blanking decision and one-hot select for the digit currently being scanned.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            nz_s[i] = |active_r[i];
        end
        lz_mask_s   = lz_mask(nz_s);
        blanked_s   = bus.blank_lz & lz_mask_s[idx_r];
        digit_sel_s = {{(DIGITS-1){1'b0}}, 1'b1} << idx_r;
    end

    assign bus.dec_number = active_r[idx_r];

    // FSM state, dwell counter and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_SCAN;
            cnt_r   <= '0;
            idx_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Double-buffered store: writes go to shadow; the copy happens only at a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                shadow_r[i] <= 4'd0;
                active_r[i] <= 4'd0;
            end
        end else begin
            if (bus.wr_en && (32'(bus.wr_idx) < DIGITS)) begin
                shadow_r[bus.wr_idx] <= bus.wr_data;
            end
            if (commit_s) begin
                active_r <= shadow_r;
            end
        end
    end

    // Registered pins; they trail the FSM by one cycle so GUARD shows as all-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r         <= 7'd0;
            digit_en_r    <= '0;
            commit_ack_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            if ((state_r == ST_SCAN) && !blanked_s) begin
                seg_r      <= bus.dec_digital;
                digit_en_r <= digit_sel_s;
            end else begin
                seg_r      <= 7'd0;
                digit_en_r <= '0;
            end
            commit_ack_r  <= commit_s;
            frame_start_r <= wrap_s;
        end
    end

    assign bus.seg         = seg_r;
    assign bus.digit_en    = digit_en_r;
    assign bus.commit_ack  = commit_ack_r;
    assign bus.frame_start = frame_start_r;
endmodule
